mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Registers the EX→MEM bus under the shared stall protocol and tracks the outstanding data-SRAM access issued by EX.
- Raises a stall request until the response arrives, buffers the response if the stage is held, then extracts and extends load data.
- Produces the MEM→WB bus and the MEM→RF forwarding bus.

Parameters:
- EX_TO_MEM_WD, 79, width of incoming EX→MEM bus.
- MEM_TO_WB_WD, 70, width of outgoing MEM→WB bus.
- MEM_TO_RF_WD, 38, width of forwarding bus.
- STALL_W, 6, width of stall vector.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  STALL_W  stall vector; bit3 = MEM, bit4 = WB; 1 = Stop.
- ex_to_mem_bus  in  79  fields, MSB→LSB:
  - {pc[78:47], data_ram_en[46], data_ram_wen[45:42], sel_rf_res[41], rf_we[40], rf_waddr[39:35], ex_result[34:3], load_type[2:0]}
- data_sram_data_ok  in  1  one-cycle pulse: response for the access EX issued.
- data_sram_rdata  in  32  read data, valid with data_ok.
- stallreq_mem  out  1  MEM requests pipeline stall.
- mem_to_wb_bus  out  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- mem_to_rf_bus  out  38  {we[37], waddr[36:32], wdata[31:0]}.

Behaviour:
- Input register bus_r:
  - rst → 0.
  - else stall[3]=Stop && stall[4]=NoStop → 0 (bubble).
  - else stall[3]=NoStop → load ex_to_mem_bus.
  - else hold.
- FSM states: IDLE, WAIT, DONE. rst → IDLE; rdata_buf → 0.
- When the stage advances (stall[3]=NoStop, not rst):
  - next state = WAIT if incoming data_ram_en=1, else IDLE.
  - Advancing overrides all other transitions.
- Otherwise:
  - WAIT & data_ok → DONE; rdata_buf ← data_sram_rdata.
  - WAIT & !data_ok → WAIT.
  - IDLE and DONE hold.
- data_ok received in IDLE or DONE: ignored. This covers stale responses after reset.
- stallreq_mem = (state==WAIT) & !data_sram_data_ok.
  - Purely a function of state and data_ok; no path from stall back to stallreq_mem.
- Raw read data: rdata_sel = (state==DONE) ? rdata_buf : data_sram_rdata.
  - Zero-latency bypass: a load completes in the cycle data_ok arrives.
- Load extraction uses addr = ex_result[1:0]:
  - load_type 000 LW: whole word.
  - 001 LB / 010 LBU: byte addr[1:0] (byte 0 = bits 7:0), sign- / zero-extended.
  - 011 LH / 100 LHU: half addr[1] (0 = bits 15:0), sign- / zero-extended; addr[0] ignored.
  - Other codes: treated as LW.
- rf_wdata = (sel_rf_res ? load_ext : ex_result). Store results are never written; EX clears rf_we for stores.
- mem_to_wb_bus rf_we = bus_r.rf_we & !stallreq_mem.
- mem_to_rf_bus = {bus_r.rf_we & !stallreq_mem, rf_waddr, rf_wdata}. No stale load value is ever forwarded.
- Stores (wen≠0) also wait for data_ok; stallreq_mem behaves the same as for loads.
- Bubble (bus_r=0): all outputs zero-valued; stallreq_mem=0.
- Reset mid-WAIT: next cycle IDLE, bus 0, stallreq_mem=0.
- Latency: combinational from bus_r/data_ok to outputs; one register stage from EX.

Decomposition:
- Shared defines header (lib/defines.vh) holds:
  - EX_TO_MEM_WD, MEM_TO_WB_WD, MEM_TO_RF_WD, StallBus.
  - Stop/NoStop.
  - LOAD_LW/LB/LBU/LH/LHU codes.
  - FSM state encodings MEM_IDLE/MEM_WAIT/MEM_DONE.
- One sub-module, load_ext: combinational (rdata, addr[1:0], load_type) → 32-bit extended value.

Test Plan:
- LW at addr 0x100, data_ok one cycle after entry, rdata 0x8765_4321 → stallreq_mem=1 for 1 cycle; then rf_wdata=0x8765_4321, we=1 to $waddr.
- LB addr[1:0]=3, rdata 0x80FF_0000 → 0xFFFF_FF80; LBU same → 0x0000_0080; LH addr[1]=1 → 0xFFFF_80FF; LHU → 0x0000_80FF.
- Load, data_ok in the same cycle as entry → stallreq_mem never asserted; value forwarded that cycle.
- data_ok arrives while stall[3]=Stop from another source (e.g. bit4 held) → state DONE, stallreq_mem=0; rdata changes afterwards; output stays the buffered value until advance.
- stall[3]=Stop, stall[4]=NoStop → bus_r zero next cycle, all outputs 0; ALU result 0x1234 with sel_rf_res=0 passes through unchanged when not stalled.
- rst asserted while in WAIT, then a stray data_ok → IDLE, stallreq_mem=0, outputs 0; data_ok ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encodings, load codes and bus layouts for the memory stage.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 79;
    localparam int MEM_TO_WB_WD = 70;
    localparam int MEM_TO_RF_WD = 38;
    localparam int STALL_W      = 6;
    localparam int DATA_W       = 32;

    localparam int STALL_MEM = 3;
    localparam int STALL_WB  = 4;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [2:0] LOAD_LW  = 3'b000;
    localparam logic [2:0] LOAD_LB  = 3'b001;
    localparam logic [2:0] LOAD_LBU = 3'b010;
    localparam logic [2:0] LOAD_LH  = 3'b011;
    localparam logic [2:0] LOAD_LHU = 3'b100;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
        logic [2:0]  load_type;
    } ex_to_mem_t;

endpackage

// File: rtl/mem_stage_load_ext.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_ext
    import mem_stage_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        addr,
    input  logic [2:0]        load_type,
    output logic [DATA_W-1:0] load_data
);

    function automatic logic [DATA_W-1:0] sext8(input logic signed [7:0] v);
        logic signed [DATA_W-1:0] w;
        w = v;
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] sext16(input logic signed [15:0] v);
        logic signed [DATA_W-1:0] w;
        w = v;
        return w;
    endfunction

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (addr)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr[1] ? rdata[31:16] : rdata[15:0];

        // Undefined load codes fall back to a full-word load.
        case (load_type)
            LOAD_LB:  load_data = sext8(byte_v);
            LOAD_LBU: load_data = {24'd0, byte_v};
            LOAD_LH:  load_data = sext16(half_v);
            LOAD_LHU: load_data = {16'd0, half_v};
            default:  load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: registers the EX bus, tracks the outstanding data-SRAM access and
// drives the write-back and forwarding buses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic                    data_sram_data_ok,
    input  logic [DATA_W-1:0]       data_sram_rdata,
    output logic                    stallreq_mem,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus
);

    ex_to_mem_t        bus_in;
    ex_to_mem_t        bus_p0;
    mem_state_e        state;
    logic [DATA_W-1:0] rdata_buf;
    logic              advance;
    logic              bubble;

    assign bus_in  = ex_to_mem_t'(ex_to_mem_bus);
    assign advance = (stall[STALL_MEM] == NO_STOP);
    assign bubble  = (stall[STALL_MEM] == STOP) && (stall[STALL_WB] == NO_STOP);

    // Stage p0: EX->MEM register
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_p0 <= '0;
        end else if (bubble) begin
            bus_p0 <= '0;
        end else if (advance) begin
            bus_p0 <= bus_in;
        end
    end

    // A new instruction entering the stage restarts tracking regardless of the old state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MEM_IDLE;
            rdata_buf <= '0;
        end else if (advance) begin
            state <= bus_in.data_ram_en ? MEM_WAIT : MEM_IDLE;
        end else begin
            case (state)
                MEM_WAIT: begin
                    if (data_sram_data_ok) begin
                        state     <= MEM_DONE;
                        rdata_buf <= data_sram_rdata;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    logic [DATA_W-1:0] rdata_sel;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_we_out;

    assign stallreq_mem = (state == MEM_WAIT) && !data_sram_data_ok;
    assign rdata_sel    = (state == MEM_DONE) ? rdata_buf : data_sram_rdata;

    load_ext u_load_ext (
        .rdata     (rdata_sel),
        .addr      (bus_p0.ex_result[1:0]),
        .load_type (bus_p0.load_type),
        .load_data (load_data)
    );

    // Write enable is held off until the access completes so no stale load value escapes.
    assign rf_wdata  = bus_p0.sel_rf_res ? load_data : bus_p0.ex_result;
    assign rf_we_out = bus_p0.rf_we && !stallreq_mem;

    assign mem_to_wb_bus = {bus_p0.pc, rf_we_out, bus_p0.rf_waddr, rf_wdata};
    assign mem_to_rf_bus = {rf_we_out, bus_p0.rf_waddr, rf_wdata};

    logic unused_ok;
    assign unused_ok = ^{stall[STALL_W-1], stall[2:0], bus_p0.data_ram_wen};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed literal scenarios plus randomized traffic against a reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [78:0] ex_bus;
    logic        data_ok;
    logic [31:0] rdata;
    logic        stallreq_mem;
    logic [69:0] wb_bus;
    logic [37:0] rf_bus;

    int tests = 0;
    int fails = 0;

    mem_stage dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .ex_to_mem_bus     (ex_bus),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata),
        .stallreq_mem      (stallreq_mem),
        .mem_to_wb_bus     (wb_bus),
        .mem_to_rf_bus     (rf_bus)
    );

    always #5 clk = ~clk;

    // Reference model: registered instruction, whether its access is still outstanding,
    // and whether a response has been captured while the stage was held.
    logic [78:0] m_bus = '0;
    bit          m_pending = 0;
    bit          m_have = 0;
    logic [31:0] m_buf = '0;
    bit          chk_en = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_bus = '0; m_pending = 0; m_have = 0; m_buf = '0;
        end else if (!stall[3]) begin
            m_bus = ex_bus; m_pending = ex_bus[46]; m_have = 0;
        end else begin
            if (!stall[4]) m_bus = '0;
            if (m_pending && data_ok) begin
                m_pending = 0; m_have = 1; m_buf = rdata;
            end
        end
        chk_en = 1;
    end

    function automatic logic [31:0] m_ext(input logic [31:0] raw, input logic [1:0] a, input logic [2:0] lt);
        logic [31:0] b, h;
        b = (raw >> (8 * a)) & 32'hFF;
        h = (raw >> (16 * a[1])) & 32'hFFFF;
        case (lt)
            3'd1:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return raw;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic        e_req, e_we;
            logic [31:0] raw, wd;
            logic [69:0] e_wb;
            logic [37:0] e_rf;
            e_req = m_pending && !data_ok;
            raw   = m_have ? m_buf : rdata;
            wd    = m_bus[41] ? m_ext(raw, m_bus[4:3], m_bus[2:0]) : m_bus[34:3];
            e_we  = m_bus[40] && !e_req;
            e_wb  = {m_bus[78:47], e_we, m_bus[39:35], wd};
            e_rf  = {e_we, m_bus[39:35], wd};
            tests += 3;
            if (stallreq_mem !== e_req) begin
                fails++; $display("FAIL model_stallreq t=%0t got %b want %b", $time, stallreq_mem, e_req);
            end
            if (wb_bus !== e_wb) begin
                fails++; $display("FAIL model_wb t=%0t got %h want %h", $time, wb_bus, e_wb);
            end
            if (rf_bus !== e_rf) begin
                fails++; $display("FAIL model_rf t=%0t got %h want %h", $time, rf_bus, e_rf);
            end
        end
    end

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [78:0] mk(input logic [31:0] pc, input logic en, input logic [3:0] wen,
                                       input logic sel, input logic we, input logic [4:0] wa,
                                       input logic [31:0] res, input logic [2:0] lt);
        return {pc, en, wen, sel, we, wa, res, lt};
    endfunction

    task automatic drive(input logic r, input logic [5:0] s, input logic [78:0] b,
                         input logic ok, input logic [31:0] rd);
        rst = r; stall = s; ex_bus = b; data_ok = ok; rdata = rd;
    endtask

    task automatic adv();
        @(posedge clk); #1;
    endtask

    task automatic samp();
        @(negedge clk); #1;
    endtask

    localparam logic [5:0] HOLD   = 6'b011111;
    localparam logic [5:0] BUBBLE = 6'b001111;

    initial begin
        logic [31:0] exp_ext [4];
        logic [2:0]  lts [4];
        logic [31:0] addrs [4];
        exp_ext = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
        lts     = '{3'd1, 3'd2, 3'd3, 3'd4};
        addrs   = '{32'h103, 32'h103, 32'h102, 32'h102};

        drive(1, 6'd0, '0, 0, 32'h0);
        adv();
        samp();
        chk("reset_stallreq", 70'(stallreq_mem), 70'd0);
        chk("reset_wb", wb_bus, 70'd0);
        chk("reset_rf", 70'(rf_bus), 70'd0);

        // LW with response one cycle after entry
        drive(0, 6'd0, mk(32'hBFC0_0000, 1, 4'd0, 1, 1, 5'd5, 32'h100, 3'd0), 0, 32'h0);
        adv();
        drive(0, HOLD, '0, 0, 32'h0);
        samp();
        chk("lw_wait_stallreq", 70'(stallreq_mem), 70'd1);
        chk("lw_wait_we", 70'(rf_bus[37]), 70'd0);
        adv();
        drive(0, 6'd0, '0, 1, 32'h8765_4321);
        samp();
        chk("lw_done_stallreq", 70'(stallreq_mem), 70'd0);
        chk("lw_done_rf", 70'(rf_bus), 70'({1'b1, 5'd5, 32'h8765_4321}));
        chk("lw_done_wb", wb_bus, {32'hBFC0_0000, 1'b1, 5'd5, 32'h8765_4321});
        adv();

        // Sub-word loads answered in the cycle they enter
        for (int i = 0; i < 4; i++) begin
            drive(0, 6'd0, mk(32'h40 + 32'(i), 1, 4'd0, 1, 1, 5'd10 + 5'(i), addrs[i], lts[i]), 0, 32'h0);
            adv();
            drive(0, 6'd0, '0, 1, 32'h80FF_0000);
            samp();
            chk("subword_stallreq", 70'(stallreq_mem), 70'd0);
            chk("subword_rf", 70'(rf_bus), 70'({1'b1, 5'd10 + 5'(i), exp_ext[i]}));
            adv();
        end

        // Response captured while held by a downstream stall
        drive(0, 6'd0, mk(32'h80, 1, 4'd0, 1, 1, 5'd9, 32'h200, 3'd0), 0, 32'h0);
        adv();
        drive(0, HOLD, '0, 1, 32'hCAFE_F00D);
        samp();
        chk("held_bypass_rf", 70'(rf_bus), 70'({1'b1, 5'd9, 32'hCAFE_F00D}));
        adv();
        drive(0, HOLD, '0, 0, 32'h1111_1111);
        samp();
        chk("held_buf_stallreq", 70'(stallreq_mem), 70'd0);
        chk("held_buf_rf", 70'(rf_bus), 70'({1'b1, 5'd9, 32'hCAFE_F00D}));
        adv();
        drive(0, 6'd0, '0, 0, 32'h0);
        adv();

        // ALU pass-through then bubble
        drive(0, 6'd0, mk(32'hC0, 0, 4'd0, 0, 1, 5'd7, 32'h1234, 3'd0), 0, 32'h0);
        adv();
        drive(0, BUBBLE, '0, 0, 32'h0);
        samp();
        chk("alu_rf", 70'(rf_bus), 70'({1'b1, 5'd7, 32'h1234}));
        adv();
        drive(0, 6'd0, '0, 0, 32'h0);
        samp();
        chk("bubble_wb", wb_bus, 70'd0);
        chk("bubble_rf", 70'(rf_bus), 70'd0);
        adv();

        // Reset while waiting, then a stray response
        drive(0, 6'd0, mk(32'hE0, 1, 4'd0, 1, 1, 5'd3, 32'h300, 3'd0), 0, 32'h0);
        adv();
        drive(0, HOLD, '0, 0, 32'h0);
        samp();
        chk("rstwait_stallreq", 70'(stallreq_mem), 70'd1);
        drive(1, HOLD, '0, 0, 32'h0);
        adv();
        drive(0, HOLD, '0, 1, 32'hDEAD_BEEF);
        samp();
        chk("stray_stallreq", 70'(stallreq_mem), 70'd0);
        chk("stray_wb", wb_bus, 70'd0);
        adv();
        drive(0, 6'd0, '0, 0, 32'h0);
        samp();
        chk("stray_after_rf", 70'(rf_bus), 70'd0);
        adv();

        for (int n = 0; n < 3000; n++) begin
            int unsigned p;
            logic [5:0]  s;
            p = $urandom_range(0, 99);
            if (p < 50)      s = 6'd0;
            else if (p < 70) s = HOLD;
            else if (p < 85) s = BUBBLE;
            else             s = 6'($urandom);
            drive($urandom_range(0, 99) < 3, s,
                  mk($urandom, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                     5'($urandom), $urandom, 3'($urandom)),
                  $urandom_range(0, 99) < 30, $urandom);
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
